fsm_step_sequencer: RTL and testbench
=====================================

// Module: fsm_step_sequencer
// PURPOSE
//   Test/bring-up controller for the team's single-bit-output practice FSMs (ports x,y,Rst,Clk,q).
//   Holds a small program of (x,y) input steps and pulses the target's reset.
//   Replays the steps one per clock and captures the target's q response per step into q_trace.
//   Sits beside the target FSM instance; the target shares Clk with this block.
// PARAMETERS
//   DEPTH  8  number of program steps (power of 2, >=2)
//   AW     3  step address width, = log2(DEPTH)
// PORTS
//   Clk        in   1      rising-edge clock (shared with target)
//   Rst        in   1      synchronous, active-high reset
//   prog_we    in   1      write prog_data to step prog_addr
//   prog_addr  in   AW     step index to write
//   prog_data  in   2      {x,y} for that step
//   len        in   AW+1   steps to run, legal 1..DEPTH; sampled at start
//   start      in   1      begin a run (accepted only in IDLE)
//   tgt_rst    out  1      reset to target FSM
//   x_out      out  1      target x input
//   y_out      out  1      target y input
//   q_in       in   1      target q output
//   busy       out  1      run in progress
//   done       out  1      one-cycle pulse: run complete, q_trace valid
//   err        out  1      sticky: start with illegal len; cleared by next legal start or Rst
//   q_trace    out  DEPTH  bit i = q response to step i; bits >= len are 0
// BEHAVIOUR
//   Reset: state=IDLE; tgt_rst, x_out, y_out, busy, done, err, q_trace = 0; all step entries = 2'b00.
//   All outputs are registered.
//   States: IDLE -> TRST -> RUN -> DRAIN -> DONE -> IDLE.
//   IDLE:  start && len in 1..DEPTH -> TRST. Same edge: latch len, clear q_trace and err, busy=1.
//          start && illegal len -> stay IDLE, err=1.
//          prog_we writes memory in IDLE only; ignored in every other state.
//          prog_we and start on the same edge: the write lands, and the run uses the new data.
//   TRST:  one cycle; tgt_rst=1, x_out=y_out=0; idx=0; -> RUN.
//   RUN:   cycle k (k=0..len-1) drives {x_out,y_out}=step[k].
//          When k>=1, the edge ending cycle k stores q_in into q_trace[k-1].
//          After cycle len-1 -> DRAIN.
//   DRAIN: x_out=y_out=0; the edge ending DRAIN stores q_in into q_trace[len-1]; -> DONE.
//   DONE:  done=1 and busy=0 for exactly one cycle; -> IDLE. q_trace holds until next accepted start.
//   Latency: start edge to done high = len+3 cycles.
//            Step k input is sampled by the target one edge later; its q is read the following edge.
//   len==DEPTH: idx stops at DEPTH-1 and must not wrap. len==1: RUN lasts one cycle and captures nothing.
//   start while busy: ignored, no error.
//   Rst mid-run (any state): next cycle in IDLE, all outputs at reset values, no done pulse.
//   Step memory is cleared by Rst.
// STRUCTURE
//   Shared package fsm_seq_pkg: state enum (IDLE,TRST,RUN,DRAIN,DONE), DEPTH/AW defaults, step typedef {x,y}.
//   Sub-module fsm_seq_step_ram: DEPTH x 2 register file with sync reset, 1 write port, 1 async read port.
//   Top holds the FSM, the idx counter, the len latch and the q_trace shift/indexed capture.
// TESTING
//   Bench loopback: q_in = x_out delayed one Clk (models a target that registers x), so expected q_trace[i] = step[i].x.
//   1 Program steps 0..3 = {1,0},{0,1},{1,1},{0,0}; len=4; start
//       -> tgt_rst high 1 cycle; x/y sequence as programmed; done at start+7; q_trace=8'b0000_0101.
//   2 len=8, all steps {1,0} -> done at start+11; q_trace=8'hFF; idx does not wrap; busy low after done.
//   3 start with len=0, then len=9 -> no busy, err=1 both times; next start with len=1 clears err,
//       done at start+4, q_trace=step[0].x.
//   4 During run: prog_we to step 0 and a second start -> memory unchanged after run, single done pulse.
//   5 Rst asserted in RUN cycle 2 -> next cycle all outputs 0, state IDLE, no done; memory reads back 0.
//   6 prog_we and start on the same edge writing step 0={1,1} -> first RUN cycle drives x_out=1, y_out=1.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
// Shared types and defaults for the step sequencer.
package fsm_seq_pkg;

  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_AW    = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_TRST  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic x;
    logic y;
  } step_t;

endpackage

// File: rtl/fsm_step_sequencer_if.sv
// Program/control and target-side signals of the step sequencer.
interface fsm_step_sequencer_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
);

  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [1:0]        prog_data;
  logic [AW:0]       len;
  logic              start;
  logic              tgt_rst;
  logic              x_out;
  logic              y_out;
  logic              q_in;
  logic              busy;
  logic              done;
  logic              err;
  logic [DEPTH-1:0]  q_trace;

  modport master (
    output prog_we, prog_addr, prog_data, len, start, q_in,
    input  tgt_rst, x_out, y_out, busy, done, err, q_trace
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, len, start, q_in,
    output tgt_rst, x_out, y_out, busy, done, err, q_trace
  );

endinterface

// File: rtl/fsm_seq_step_ram.sv
// DEPTH x 2 step register file: sync reset, one write port, async read.
module fsm_seq_step_ram
  import fsm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  step_t         wdata,
  input  logic [AW-1:0] raddr,
  output step_t         rdata
);

  step_t mem_q [DEPTH];
  step_t mem_d [DEPTH];

  // Next memory contents: single write port.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fsm_step_sequencer.sv
// Bring-up controller: replays programmed (x,y) steps into a target FSM
// after pulsing its reset, and records the target's q per step.
module fsm_step_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW
) (
  input logic               Clk,
  input logic               Rst,
  fsm_step_sequencer_if.slave bus
);

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW:0]      len_q, len_d;
  logic             tgt_rst_q, tgt_rst_d;
  logic             x_out_q, x_out_d;
  logic             y_out_q, y_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [DEPTH-1:0] q_trace_q, q_trace_d;

  logic             mem_we;
  logic [AW-1:0]    rd_addr;
  step_t            rd_step;
  logic             len_legal;
  logic             last_step;
  logic [AW-1:0]    last_idx;

  // Program writes are only honoured while idle.
  assign mem_we    = bus.prog_we && (state_q == ST_IDLE);
  assign len_legal = (bus.len != '0) && (bus.len <= (AW+1)'(DEPTH));
  assign last_step = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));
  assign last_idx  = AW'(len_q - (AW+1)'(1));

  fsm_seq_step_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (Clk),
    .rst   (Rst),
    .we    (mem_we),
    .waddr (bus.prog_addr),
    .wdata (step_t'(bus.prog_data)),
    .raddr (rd_addr),
    .rdata (rd_step)
  );

  // Next-state and registered-output logic; rd_addr selects the step driven next cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    tgt_rst_d = 1'b0;
    x_out_d   = 1'b0;
    y_out_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    q_trace_d = q_trace_q;
    rd_addr   = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (len_legal) begin
            state_d   = ST_TRST;
            len_d     = bus.len;
            idx_d     = '0;
            q_trace_d = '0;
            err_d     = 1'b0;
            busy_d    = 1'b1;
            tgt_rst_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_TRST: begin
        state_d = ST_RUN;
        idx_d   = '0;
        rd_addr = '0;
        x_out_d = rd_step.x;
        y_out_d = rd_step.y;
      end
      ST_RUN: begin
        // q for the previous step is valid now (one edge into, one edge out of the target).
        if (idx_q != '0) q_trace_d[idx_q - AW'(1)] = bus.q_in;
        if (last_step) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d   = idx_q + AW'(1);
          rd_addr = idx_q + AW'(1);
          x_out_d = rd_step.x;
          y_out_d = rd_step.y;
        end
      end
      ST_DRAIN: begin
        q_trace_d[last_idx] = bus.q_in;
        state_d = ST_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      tgt_rst_q <= 1'b0;
      x_out_q   <= 1'b0;
      y_out_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      q_trace_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      tgt_rst_q <= tgt_rst_d;
      x_out_q   <= x_out_d;
      y_out_q   <= y_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      q_trace_q <= q_trace_d;
    end
  end

  assign bus.tgt_rst = tgt_rst_q;
  assign bus.x_out   = x_out_q;
  assign bus.y_out   = y_out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.q_trace = q_trace_q;

endmodule

// File: tb/tb_fsm_step_sequencer.sv
// Bench for fsm_step_sequencer with a one-flop loopback target (q = x delayed).
module tb_fsm_step_sequencer;

  logic clk;
  logic rst;

  fsm_step_sequencer_if #(.DEPTH(8), .AW(3)) bus ();

  fsm_step_sequencer #(.DEPTH(8), .AW(3)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback target: registers x.
  always @(posedge clk) bus.q_in <= rst ? 1'b0 : bus.x_out;

  logic [1:0] model [8];
  logic [1:0] step_q [$];
  logic [7:0] qt_q [$];
  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int addr, input logic [1:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 3'(addr);
    bus.prog_data = data;
    cyc();
    bus.prog_we   = 1'b0;
    model[addr]   = data;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tgt_rst"}, 32'(bus.tgt_rst), 0);
    chk({tag, "_xy"},      32'({bus.x_out, bus.y_out}), 0);
    chk({tag, "_busy"},    32'(bus.busy), 0);
    chk({tag, "_done"},    32'(bus.done), 0);
    chk({tag, "_err"},     32'(bus.err), 0);
    chk({tag, "_q_trace"}, 32'(bus.q_trace), 0);
  endtask

  // One run: expectations are queued at start, consumed as the DUT produces them.
  task automatic run(input int l, input bit disturb);
    logic [7:0] eq;
    logic [1:0] es;
    int n;
    bit seen;
    eq = '0;
    for (int i = 0; i < l; i++) begin
      step_q.push_back(model[i]);
      eq[i] = model[i][1];
    end
    qt_q.push_back(eq);
    bus.len   = 4'(l);
    bus.start = 1'b1;
    cyc();
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    n = 1;
    chk("trst_tgt_rst", 32'(bus.tgt_rst), 1);
    chk("trst_busy",    32'(bus.busy), 1);
    chk("trst_xy",      32'({bus.x_out, bus.y_out}), 0);
    chk("trst_err",     32'(bus.err), 0);
    chk("trst_done",    32'(bus.done), 0);
    for (int k = 0; k < l; k++) begin
      cyc();
      n++;
      bus.prog_we = 1'b0;
      bus.start   = 1'b0;
      es = (step_q.size() != 0) ? step_q.pop_front() : 2'bxx;
      chk("run_tgt_rst", 32'(bus.tgt_rst), 0);
      chk("run_xy",      32'({bus.x_out, bus.y_out}), 32'(es));
      chk("run_busy",    32'(bus.busy), 1);
      if (disturb && k == 0) begin
        bus.prog_we   = 1'b1;
        bus.prog_addr = 3'd0;
        bus.prog_data = ~model[0];
        bus.start     = 1'b1;
        bus.len       = 4'd3;
      end
    end
    cyc();
    n++;
    bus.prog_we = 1'b0;
    bus.start   = 1'b0;
    chk("drain_xy",   32'({bus.x_out, bus.y_out}), 0);
    chk("drain_done", 32'(bus.done), 0);
    seen = 1'b0;
    for (int j = 0; j < 4 && !seen; j++) begin
      cyc();
      n++;
      if (bus.done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 1);
    eq = (qt_q.size() != 0) ? qt_q.pop_front() : 8'hxx;
    if (seen) begin
      chk("done_latency", 32'(n), 32'(l + 3));
      chk("done_busy",    32'(bus.busy), 0);
      chk("q_trace",      32'(bus.q_trace), 32'(eq));
    end
    cyc();
    chk("done_pulse",   32'(bus.done), 0);
    chk("idle_busy",    32'(bus.busy), 0);
    chk("q_trace_hold", 32'(bus.q_trace), 32'(eq));
  endtask

  initial begin
    bit seen;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.len       = '0;
    bus.start     = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 2'b00;
    cyc();
    cyc();
    chk_all_zero("reset");
    rst = 1'b0;
    cyc();

    // 1: four programmed steps
    prog(0, 2'b10);
    prog(1, 2'b01);
    prog(2, 2'b11);
    prog(3, 2'b00);
    run(4, 1'b0);

    // 2: full depth, all {1,0}
    for (int i = 0; i < 8; i++) prog(i, 2'b10);
    run(8, 1'b0);

    // 3: illegal lengths set err, legal start clears it
    bus.len   = 4'd0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("len0_busy", 32'(bus.busy), 0);
    chk("len0_err",  32'(bus.err), 1);
    cyc();
    chk("len0_idle", 32'(bus.tgt_rst), 0);
    bus.len   = 4'd9;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("len9_busy", 32'(bus.busy), 0);
    chk("len9_err",  32'(bus.err), 1);
    cyc();
    run(1, 1'b0);
    chk("err_cleared", 32'(bus.err), 0);

    // 4: write and start during a run are ignored
    run(3, 1'b1);
    seen = 1'b0;
    for (int j = 0; j < 6; j++) begin
      cyc();
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("no_second_run", 32'(seen), 0);
    chk("no_err_busy_start", 32'(bus.err), 0);
    run(1, 1'b0);

    // 5: reset mid-run
    bus.len   = 4'd8;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 2'b00;
    chk_all_zero("midrst");
    seen = 1'b0;
    for (int j = 0; j < 12; j++) begin
      cyc();
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 0);
    run(8, 1'b0);

    // 6: write and start on the same edge
    bus.prog_we   = 1'b1;
    bus.prog_addr = 3'd0;
    bus.prog_data = 2'b11;
    model[0]      = 2'b11;
    run(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
